// File: rtl/bus_pkg.sv
// Shared bus types and the arbiter state encoding used by the bus
// arbitration logic beside the CPU.
package bus_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] bus_data_t;
    typedef logic [ADDR_WIDTH-1:0] bus_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GRANT,
        GAP,
        RETURN
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first pending index
// strictly after the pointer, wrapping around to the lowest index.
module rr_pick
    import bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [OWNER_W-1:0] ptr,
    output logic               found,
    output logic [OWNER_W-1:0] index
);

    logic               hi_found;
    logic               lo_found;
    logic [OWNER_W-1:0] hi_index;
    logic [OWNER_W-1:0] lo_index;

    // Scanning downwards leaves the lowest match in each half: above the
    // pointer wins, otherwise the wrap-around candidate is used.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_index = '0;
        lo_index = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending[i[OWNER_W-1:0]]) begin
                lo_found = 1'b1;
                lo_index = i[OWNER_W-1:0];
                if (i > int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_index = i[OWNER_W-1:0];
                end
            end
        end
        found = hi_found | lo_found;
        index = hi_found ? hi_index : lo_index;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Takes the bus from the CPU via busrq_n/busack_n and hands it to the
// secondary masters one at a time in round-robin order.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int MAX_BURST = 4,
    localparam int OWNER_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BURST_W   = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_n,
    input  logic               busack_n,
    output logic               busrq_n,
    output logic [NUM_REQ-1:0] grant_n,
    output logic [OWNER_W-1:0] owner,
    output logic               owner_valid
);

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [OWNER_W-1:0] ptr_q;
    logic [OWNER_W-1:0] ptr_d;
    logic [OWNER_W-1:0] owner_d;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] burst_d;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] grant_d;
    logic               busrq_d;
    logic               burst_ok;
    logic               pick_found;
    logic [OWNER_W-1:0] pick_index;

    assign pending = ~req_n;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .OWNER_W(OWNER_W)
    ) u_pick (
        .pending(pending),
        .ptr    (ptr_q),
        .found  (pick_found),
        .index  (pick_index)
    );

    // Outputs are derived from the next state so they leave a flop directly.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner;
        burst_d  = burst_q;
        burst_ok = (MAX_BURST == 0) || (burst_q < BURST_LIMIT);

        case (state_q)
            IDLE: begin
                if (|pending) state_d = REQ;
            end
            REQ: begin
                if (!busack_n) begin
                    if (pick_found) begin
                        state_d = GRANT;
                        ptr_d   = pick_index;
                        owner_d = pick_index;
                        burst_d = BURST_W'(1);
                    end else begin
                        state_d = RETURN;
                    end
                end
            end
            GRANT: begin
                if (req_n[owner]) state_d = GAP;
            end
            GAP: begin
                if (pick_found && burst_ok) begin
                    state_d = GRANT;
                    ptr_d   = pick_index;
                    owner_d = pick_index;
                    if (MAX_BURST != 0) burst_d = burst_q + BURST_W'(1);
                end else begin
                    state_d = RETURN;
                end
            end
            RETURN: begin
                if (busack_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busrq_d = !(state_d inside {REQ, GRANT, GAP});
        grant_d = '1;
        if (state_d == GRANT) grant_d[owner_d] = 1'b0;
    end

    // The pointer starts on the last index so master 0 wins the first pick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= OWNER_W'(NUM_REQ - 1);
            burst_q     <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            grant_n     <= '1;
            busrq_n     <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            burst_q     <= burst_d;
            owner       <= owner_d;
            owner_valid <= (state_d == GRANT);
            grant_n     <= grant_d;
            busrq_n     <= busrq_d;
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares the system bus between the CPU and up to `NUM_REQ` secondary bus masters (DMA, debug port) using the CPU's `busrq_n`/`busack_n` hold protocol. It collects active-low requests, takes the bus from the CPU, and grants it to one requester at a time in round-robin order. It returns the bus to the CPU when no requests remain or a burst limit is reached. It sits beside the CPU on the shared `addr`/`data`/control bus; address decode is outside the block.

## Interface
Parameters:
- `NUM_REQ`, 2: number of secondary masters, 1..8.
- `MAX_BURST`, 4: maximum consecutive grants per CPU hold; 0 means unlimited.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous active-low reset.
- `req_n`  input  NUM_REQ  per-master bus request, active-low, level-held until the master finishes.
- `busack_n`  input  1  CPU bus acknowledge, active-low.
- `busrq_n`  output  1  bus request to the CPU, active-low.
- `grant_n`  output  NUM_REQ  per-master grant, active-low, one-hot-or-none.
- `owner`  output  OWNER_W  index of the current grantee, where OWNER_W = max(1, $clog2(NUM_REQ)).
- `owner_valid`  output  1  high while any `grant_n` bit is low.

## Operation
- Reset values: `busrq_n`=1, `grant_n`=all 1, `owner`=0, `owner_valid`=0, round-robin pointer=NUM_REQ-1 (so index 0 wins first), burst count=0, state IDLE.
- IDLE: if any `req_n` is low, go to REQ.
- REQ: `busrq_n`=0. On `busack_n`=0:
  - If any request is pending, go to GRANT. Pick the first pending index after the pointer, wrapping. Set the pointer to the picked index and the burst count to 1.
  - If no request is pending, go to RETURN.
- GRANT: `grant_n[owner]`=0 and `busrq_n`=0. Stay until `req_n[owner]`=1, then go to GAP. Requests from other masters never preempt the owner.
- GAP: one turnaround cycle with all grants high and `busrq_n`=0.
  - If a request is pending and (MAX_BURST==0 or burst count < MAX_BURST), go to GRANT with a round-robin pick; burst count +1.
  - Otherwise go to RETURN.
- RETURN: `busrq_n`=1. Wait for `busack_n`=1, then go to IDLE. A pending request is reconsidered only from IDLE, which guarantees the CPU at least one owned cycle.
- `busack_n` deasserting during GRANT (protocol violation): hold the grant anyway. No recovery action.
- Burst counter saturates at MAX_BURST. Its width is $clog2(MAX_BURST+1), minimum 1.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Request to `busrq_n` low: 1 cycle (the `req_n` low sample takes IDLE to REQ).
- `busack_n` low sample to `grant_n` low: 1 cycle.
- `req_n[owner]` high sample to `grant_n[owner]` high: 1 cycle. The next grant follows 1 cycle later, after GAP.
- Last release to `busrq_n` high: 2 cycles (GAP, then RETURN).
- Simultaneous requests at pick time: strict round-robin from pointer+1.
- A requester whose `req_n` rises before it is granted is simply not picked.
- Async reset mid-grant: all outputs go inactive immediately. Masters must tolerate an abrupt grant loss.

## Structure
- Package `bus_pkg`:
  - `bus_data_t` and `bus_addr_t` (DATA_WIDTH 8, ADDR_WIDTH 16).
  - `arb_state_t` enum: IDLE, REQ, GRANT, GAP, RETURN.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: pending vector, pointer.
  - Outputs: `found`, `index`.

## Test plan
- Reset, then master 0 pulls `req_n[0]` low; CPU model acks 2 cycles after `busrq_n` low. Expect `busrq_n` low 1 cycle after the request, `grant_n`=2'b10 1 cycle after the ack, and `owner`=0 with `owner_valid`=1.
- Both masters request continuously with MAX_BURST=4. Expect grant order 0,1,0,1, each grant separated by one GAP cycle. Then `busrq_n` goes high, and the sequence re-requests only after `busack_n` returns high.
- Master 1 holds the bus for 10 cycles while master 0 requests. Expect no preemption, and a grant to master 0 exactly 2 cycles after `req_n[1]` rises.
- Request withdrawn before the ack: `req_n[0]` low for 1 cycle, ack arrives 3 cycles later. Expect no grant, and REQ then RETURN with `busrq_n` high 1 cycle after the ack.
- Assert `reset_n` low mid-GRANT. Expect `grant_n` all ones and `busrq_n`=1 immediately (asynchronously). After release, expect IDLE and master 0 winning first.
